// File: rtl/hazard_pkg.sv
// Shared types and encodings for the hazard/forwarding scoreboard.
// Entry fields are sized for the widest supported configuration.
package hazard_pkg;

    localparam int RD_W  = 8;
    localparam int LAT_W = 8;

    localparam int FWD_RF  = 0;
    localparam int FWD_MEM = 1;
    localparam int FWD_WB  = 2;

    localparam int LAT_ALU  = 1;
    localparam int LAT_LOAD = 2;

    typedef struct packed {
        logic             valid;
        logic [RD_W-1:0]  rd;
        logic [LAT_W-1:0] lat;
    } entry_t;

    // Zero latency behaves as a single cycle; anything past the tracked depth saturates.
    function automatic logic [LAT_W-1:0] clamp_lat(input int lat, input int depth);
        if (lat < 1)
            return LAT_W'(1);
        else if (lat >= depth)
            return LAT_W'(depth - 1);
        else
            return LAT_W'(lat);
    endfunction

endpackage

// File: rtl/sb_port_match.sv
// Youngest-first search of the in-flight writers for one source operand.
// Produces the hit, whether the value is not yet ready, and the forward stage.
module sb_port_match
    import hazard_pkg::*;
#(
    parameter int NE = 2,
    parameter int AW = 5,
    parameter int SW = 2
) (
    input  entry_t [NE-1:0] ents,
    input  logic [AW-1:0]   rs,
    input  logic            en,
    output logic            hit,
    output logic            hazard,
    output logic [SW-1:0]   sel
);

    always_comb begin
        hit    = 1'b0;
        hazard = 1'b0;
        sel    = '0;
        // Walk oldest to youngest so the youngest match is the one left standing.
        for (int a = NE - 1; a >= 0; a--) begin
            if (en && (rs != '0) && ents[a].valid && (ents[a].rd == RD_W'(rs))) begin
                hit    = 1'b1;
                hazard = LAT_W'(a + 1) < ents[a].lat;
                sel    = hazard ? '0 : SW'(a + 1);
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Scoreboard of in-flight register writes from EX onward: ID stall,
// flush kill of young entries, and per-port forwarding selects.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NREG      = 32,
    parameter int NRD       = 2,
    parameter int DEPTH     = 3,
    parameter int FLUSH_AGE = 1,
    parameter int CW        = 32,
    localparam int AW       = $clog2(NREG),
    localparam int SW       = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              issue_valid,
    input  logic [NRD*AW-1:0] issue_rs,
    input  logic [NRD-1:0]    issue_rs_en,
    input  logic [AW-1:0]     issue_rd,
    input  logic              issue_rd_en,
    input  logic [SW-1:0]     issue_lat,
    input  logic              flush,
    output logic              stall,
    output logic [NRD*SW-1:0] fwd_sel,
    output logic [CW-1:0]     stall_cnt
);

    // The oldest stage is never kept: the register file is write-first,
    // so a writer there is already visible to ID and can be dropped.
    localparam int NE = DEPTH - 1;

    entry_t [NE-1:0] ents;
    entry_t          ins;
    logic [NRD-1:0]  hit;
    logic [NRD-1:0]  haz;

    for (genvar k = 0; k < NRD; k++) begin : g_port
        sb_port_match #(
            .NE (NE),
            .AW (AW),
            .SW (SW)
        ) u_match (
            .ents   (ents),
            .rs     (issue_rs[k*AW +: AW]),
            .en     (issue_rs_en[k]),
            .hit    (hit[k]),
            .hazard (haz[k]),
            .sel    (fwd_sel[k*SW +: SW])
        );
    end

    assign stall = issue_valid & ~flush & (|(hit & haz));

    always_comb begin
        ins = '0;
        if (issue_valid && !stall && !flush && issue_rd_en && (issue_rd != '0)) begin
            ins.valid = 1'b1;
            ins.rd    = RD_W'(issue_rd);
            ins.lat   = clamp_lat(int'(issue_lat), DEPTH);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ents      <= '0;
            stall_cnt <= '0;
        end else begin
            ents[0] <= ins;
            for (int i = 1; i < NE; i++)
                ents[i] <= (flush && (i - 1) < FLUSH_AGE) ? '0 : ents[i-1];
            if (stall && !(&stall_cnt))
                stall_cnt <= stall_cnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: a DEPTH=3 core instance and a
// DEPTH=5 instance with a narrow stall counter for saturation.
module tb_hazard_scoreboard;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // DEPTH = 3 instance
    logic        iv3, rde3, fl3;
    logic [9:0]  rs3;
    logic [1:0]  en3;
    logic [4:0]  rd3;
    logic [1:0]  lat3;
    logic        stall3;
    logic [3:0]  fwd3;
    logic [31:0] cnt3;

    // DEPTH = 5 instance, 2-bit counter
    logic        iv5, rde5, fl5;
    logic [9:0]  rs5;
    logic [1:0]  en5;
    logic [4:0]  rd5;
    logic [2:0]  lat5;
    logic        stall5;
    logic [5:0]  fwd5;
    logic [1:0]  cnt5;

    hazard_scoreboard #(.NREG(32), .NRD(2), .DEPTH(3), .FLUSH_AGE(1), .CW(32)) dut3 (
        .clk(clk), .reset(rst), .issue_valid(iv3), .issue_rs(rs3), .issue_rs_en(en3),
        .issue_rd(rd3), .issue_rd_en(rde3), .issue_lat(lat3), .flush(fl3),
        .stall(stall3), .fwd_sel(fwd3), .stall_cnt(cnt3)
    );

    hazard_scoreboard #(.NREG(32), .NRD(2), .DEPTH(5), .FLUSH_AGE(1), .CW(2)) dut5 (
        .clk(clk), .reset(rst), .issue_valid(iv5), .issue_rs(rs5), .issue_rs_en(en5),
        .issue_rd(rd5), .issue_rd_en(rde5), .issue_lat(lat5), .flush(fl5),
        .stall(stall5), .fwd_sel(fwd5), .stall_cnt(cnt5)
    );

    typedef enum int {S3, F3A, F3B, C3, S5, F5A, C5} sig_e;
    typedef struct {
        string       tag;
        sig_e        sig;
        logic [31:0] val;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    function automatic logic [31:0] observe(input sig_e s);
        case (s)
            S3:      return {31'd0, stall3};
            F3A:     return {30'd0, fwd3[1:0]};
            F3B:     return {30'd0, fwd3[3:2]};
            C3:      return cnt3;
            S5:      return {31'd0, stall5};
            F5A:     return {29'd0, fwd5[2:0]};
            default: return {30'd0, cnt5};
        endcase
    endfunction

    task automatic push(input string tag, input sig_e s, input int v);
        exp_t e;
        e.tag = tag;
        e.sig = s;
        e.val = 32'(v);
        q.push_back(e);
    endtask

    task automatic check();
        exp_t        e;
        logic [31:0] obs;
        while (q.size() > 0) begin
            e   = q.pop_front();
            obs = observe(e.sig);
            n_chk++;
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic drive3(input logic v, input int r0, input logic e0, input int r1, input logic e1,
                          input int rd, input logic rde, input int lat, input logic fl);
        iv3  = v;
        rs3  = {5'(r1), 5'(r0)};
        en3  = {e1, e0};
        rd3  = 5'(rd);
        rde3 = rde;
        lat3 = 2'(lat);
        fl3  = fl;
    endtask

    task automatic drive5(input logic v, input int r0, input logic e0,
                          input int rd, input logic rde, input int lat);
        iv5  = v;
        rs5  = {5'd0, 5'(r0)};
        en5  = {1'b0, e0};
        rd5  = 5'(rd);
        rde5 = rde;
        lat5 = 3'(lat);
        fl5  = 1'b0;
    endtask

    initial begin
        drive3(0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive5(0, 0, 0, 0, 0, 0);

        // Reset state
        #3;
        push("rst_stall3", S3, 0); push("rst_fwd3a", F3A, 0); push("rst_fwd3b", F3B, 0);
        push("rst_cnt3", C3, 0); push("rst_stall5", S5, 0); push("rst_cnt5", C5, 0);
        check();
        @(negedge clk); rst = 1'b1;

        // Load-use: add x5, lw x5, add x6,x5,x7
        @(negedge clk); drive3(1, 0, 0, 0, 0, 5, 1, 1, 0);
        @(negedge clk); drive3(1, 0, 0, 0, 0, 5, 1, 2, 0);
        #1; push("lu_lw_stall", S3, 0); check();
        @(negedge clk); drive3(1, 5, 1, 7, 1, 6, 1, 1, 0);
        #1; push("lu_stall", S3, 1); push("lu_stall_fwd0", F3A, 0); push("lu_cnt0", C3, 0); check();
        @(negedge clk);
        #1; push("lu_release", S3, 0); push("lu_fwd0_wb", F3A, 2); push("lu_fwd1_rf", F3B, 0);
        push("lu_cnt1", C3, 1); check();

        // ALU chain: add x1, sub x2,x1,x1, or x3,x1,x2
        @(negedge clk); drive3(1, 0, 0, 0, 0, 1, 1, 1, 0);
        @(negedge clk); drive3(1, 1, 1, 1, 1, 2, 1, 1, 0);
        #1; push("alu_sub_stall", S3, 0); push("alu_sub_fwd0", F3A, 1); push("alu_sub_fwd1", F3B, 1); check();
        @(negedge clk); drive3(1, 1, 1, 2, 1, 3, 1, 1, 0);
        #1; push("alu_or_stall", S3, 0); push("alu_or_fwd0", F3A, 2); push("alu_or_fwd1", F3B, 1); check();

        // WAW on x4 and the x0 writer
        @(negedge clk); drive3(1, 0, 0, 0, 0, 4, 1, 2, 0);
        @(negedge clk); drive3(1, 0, 0, 0, 0, 4, 1, 1, 0);
        @(negedge clk); drive3(1, 4, 1, 0, 1, 0, 0, 1, 0);
        #1; push("waw_stall", S3, 0); push("waw_fwd0", F3A, 1); push("waw_x0_fwd1", F3B, 0); check();
        @(negedge clk); drive3(1, 0, 0, 0, 0, 0, 1, 1, 0);
        @(negedge clk); drive3(1, 0, 1, 4, 1, 0, 0, 1, 0);
        #1; push("x0_fwd0", F3A, 0); push("x0_old_x4_fwd1", F3B, 0); check();

        // Flush with a pending load-use hazard
        @(negedge clk); drive3(1, 0, 0, 0, 0, 9, 1, 2, 0);
        @(negedge clk); drive3(1, 9, 1, 0, 0, 0, 0, 1, 1);
        #1; push("flush_stall", S3, 0); check();
        @(negedge clk); drive3(1, 9, 1, 0, 0, 0, 0, 1, 0);
        #1; push("flush_gone_stall", S3, 0); push("flush_gone_fwd0", F3A, 0); push("flush_cnt", C3, 1); check();

        // Reset asserted during a stall
        @(negedge clk); drive3(1, 0, 0, 0, 0, 10, 1, 2, 0);
        @(negedge clk); drive3(1, 10, 1, 0, 0, 0, 0, 1, 0);
        #1; push("mid_stall", S3, 1); check();
        rst = 1'b0;
        #1; push("mid_rst_stall", S3, 0); push("mid_rst_cnt", C3, 0); check();
        @(negedge clk); rst = 1'b1;
        #1; push("post_rst_stall", S3, 0); push("post_rst_fwd0", F3A, 0); push("post_rst_fwd1", F3B, 0); check();
        @(negedge clk); drive3(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // DEPTH=5: latency-4 producer, dependent issued back to back
        @(negedge clk); drive5(1, 0, 0, 8, 1, 4);
        #1; push("deep_prod_stall", S5, 0); check();
        @(negedge clk); drive5(1, 8, 1, 0, 0, 1);
        #1; push("deep_stall1", S5, 1); push("deep_cnt0", C5, 0); check();
        @(negedge clk);
        #1; push("deep_stall2", S5, 1); push("deep_cnt1", C5, 1); check();
        @(negedge clk);
        #1; push("deep_stall3", S5, 1); push("deep_cnt2", C5, 2); check();
        @(negedge clk);
        #1; push("deep_release", S5, 0); push("deep_fwd", F5A, 4); push("deep_cnt3", C5, 3); check();

        // Counter saturation at all-ones
        @(negedge clk); drive5(1, 0, 0, 9, 1, 2);
        @(negedge clk); drive5(1, 9, 1, 0, 0, 1);
        #1; push("sat_stall", S5, 1); check();
        @(negedge clk);
        #1; push("sat_release", S5, 0); push("sat_fwd", F5A, 2); push("sat_cnt", C5, 3); check();

        // Latency above the tracked depth is clamped to DEPTH-1
        @(negedge clk); drive5(1, 0, 0, 11, 1, 7);
        @(negedge clk); drive5(1, 11, 1, 0, 0, 1);
        #1; push("clamp_stall1", S5, 1); check();
        @(negedge clk);
        #1; push("clamp_stall2", S5, 1); check();
        @(negedge clk);
        #1; push("clamp_stall3", S5, 1); check();
        @(negedge clk);
        #1; push("clamp_release", S5, 0); push("clamp_fwd", F5A, 4); check();

        // Latency 0 acts as 1
        @(negedge clk); drive5(1, 0, 0, 12, 1, 0);
        @(negedge clk); drive5(1, 12, 1, 0, 0, 1);
        #1; push("lat0_stall", S5, 0); push("lat0_fwd", F5A, 1); check();
        @(negedge clk); drive5(0, 0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
